// File: rtl/store_defs.sv
// Shared definitions for the store_rmw slice: op and FSM encodings, read-latency bounds,
// and the alignment rule used when STORE_ALIGN_CHECK_EN is defined.
package store_defs;

    typedef enum logic [1:0] {
        OP_SB  = 2'b00,
        OP_SH  = 2'b01,
        OP_SW  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 3;

    // Halfwords need an even address; words need a word-aligned address.
    function automatic logic is_misaligned(op_e op, logic [1:0] off);
        return ((op == OP_SH) && off[0]) || ((op == OP_SW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_rmw_if.sv
// Request/completion handshake from the control FSM plus the word-wide data memory port.
// master = control FSM and memory side, slave = store_rmw.
interface store_rmw_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic              busy;
    logic              done;
    logic              addr_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output start, op, addr, data, mem_rdata,
        input  busy, done, addr_err, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport slave (
        input  start, op, addr, data, mem_rdata,
        output busy, done, addr_err, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/store_lane_merge.sv
// Combinational byte-lane merge: overlays the SB/SH/SW source onto the word read back
// from memory, little-endian lanes, unselected lanes pass through.
module store_lane_merge
    import store_defs::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  op_e         op,
    input  logic [1:0]  byte_off,
    output logic [31:0] merged
);

    logic [3:0]  lane_mask;
    logic [31:0] src;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        lane_mask = 4'b0000;
        src       = data;
        case (op)
            OP_SB: begin
                lane_mask = 4'b0001 << byte_off;
                src       = {4{data[7:0]}};
            end
            OP_SH: begin
                lane_mask = byte_off[1] ? 4'b1100 : 4'b0011;
                src       = {2{data[15:0]}};
            end
            OP_SW:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = lane_mask[k] ? src[8*k +: 8] : old_word[8*k +: 8];
        end
    end

endmodule

// File: rtl/store_rmw.sv
// Store-path narrowing unit: SB/SH by read-modify-write, SW by direct write, one-cycle done.
// Define STORE_ALIGN_CHECK_EN to reject misaligned SH/SW with addr_err instead of executing them.
module store_rmw
    import store_defs::*;
#(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input logic        clk,
    input logic        rst,
    store_rmw_if.slave bus
);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
        $error("store_rmw: READ_LAT out of range 1..3");
    end

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    state_e            state, state_n;
    op_e               op_in, op_q;
    logic [1:0]        off_q;
    logic [1:0]        lat_cnt;
    logic [31:0]       data_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              accept;
    logic              last_wait;
    logic              misaligned_in;

    assign op_in     = op_e'(bus.op);
    assign accept    = (state == S_IDLE) && bus.start;
    assign last_wait = (state == S_WAIT) && (lat_cnt == LAT_LAST);

`ifdef STORE_ALIGN_CHECK_EN
    logic err_q;
    assign misaligned_in = is_misaligned(op_in, bus.addr[1:0]);
    assign bus.addr_err  = (state == S_DONE) && err_q;
`else
    assign misaligned_in = 1'b0;
    assign bus.addr_err  = 1'b0;
`endif

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = wdata_q;

    store_lane_merge u_merge (
        .old_word (bus.mem_rdata),
        .data     (data_q),
        .op       (op_q),
        .byte_off (off_q),
        .merged   (merged)
    );

    always_comb begin
        state_n    = state;
        bus.busy   = (state != S_IDLE);
        bus.done   = (state == S_DONE);
        bus.mem_re = (state == S_RD);
        bus.mem_we = (state == S_WR);
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (misaligned_in || (op_in == OP_RSV)) state_n = S_DONE;
                    else if (op_in == OP_SW)                 state_n = S_WR;
                    else                                     state_n = S_RD;
                end
            end
            S_RD:    state_n = S_WAIT;
            S_WAIT:  if (lat_cnt == LAT_LAST) state_n = S_WR;
            S_WR:    state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the pre-edge values and process ordering cannot change the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OP_SB;
            off_q      <= 2'b00;
            lat_cnt    <= 2'b00;
            data_q     <= 32'h0;
            wdata_q    <= 32'h0;
            mem_addr_q <= '0;
`ifdef STORE_ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (accept) begin
                op_q       <= op_in;
                off_q      <= bus.addr[1:0];
                data_q     <= bus.data;
                lat_cnt    <= 2'b00;
                mem_addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
                if (op_in == OP_SW) wdata_q <= bus.data;
`ifdef STORE_ALIGN_CHECK_EN
                err_q      <= misaligned_in;
`endif
            end
            if (state == S_WAIT) lat_cnt <= lat_cnt + 2'd1;
            // Read data is only guaranteed in the last WAIT cycle.
            if (last_wait) wdata_q <= merged;
        end
    end

endmodule

// File: tb/tb_store_rmw.sv
// Self-checking bench for store_rmw: two instances (READ_LAT 1 and 3) share stimulus,
// a latency-accurate memory model and a byte-array reference model.
module tb_store_rmw;
    import store_defs::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        int          re_cyc;
        int          we_cyc;
        int          done_cyc;
        int          n_re;
        int          n_we;
        logic [31:0] we_data;
        logic [31:0] we_addr;
        logic        err;
        logic        overlap;
        logic        busy_bad;
        logic        idle_after;
        logic [31:0] hold_addr;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [31:0] rd_word;
    int          rd_ready = -1;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [0:1023];

    store_rmw_if #(.ADDR_W(32)) bus_a ();
    store_rmw_if #(.ADDR_W(32)) bus_b ();

    assign bus_a.start     = start & ~sel;
    assign bus_a.op        = op;
    assign bus_a.addr      = addr;
    assign bus_a.data      = data;
    assign bus_a.mem_rdata = rdata;
    assign bus_b.start     = start & sel;
    assign bus_b.op        = op;
    assign bus_b.addr      = addr;
    assign bus_b.data      = data;
    assign bus_b.mem_rdata = rdata;

    store_rmw #(.ADDR_W(32), .READ_LAT(LAT_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    store_rmw #(.ADDR_W(32), .READ_LAT(LAT_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    wire        o_busy  = sel ? bus_b.busy      : bus_a.busy;
    wire        o_done  = sel ? bus_b.done      : bus_a.done;
    wire        o_err   = sel ? bus_b.addr_err  : bus_a.addr_err;
    wire        o_re    = sel ? bus_b.mem_re    : bus_a.mem_re;
    wire        o_we    = sel ? bus_b.mem_we    : bus_a.mem_we;
    wire [31:0] o_addr  = sel ? bus_b.mem_addr  : bus_a.mem_addr;
    wire [31:0] o_wdata = sel ? bus_b.mem_wdata : bus_a.mem_wdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory returns the addressed word only in the cycle READ_LAT after mem_re; X otherwise.
    always @(negedge clk) begin
        if (o_re) begin
            rd_ready <= cyc + (sel ? LAT_B : LAT_A);
            rd_word  <= mem[o_addr[11:2]];
        end
        rdata <= (cyc == rd_ready) ? rd_word : 32'hxxxx_xxxx;
    end

    function automatic logic [31:0] ref_word(input logic [31:0] old_w, input logic [31:0] d,
                                             input logic [1:0] o, input logic [1:0] off);
        logic [7:0] b [4];
        int base;
        for (int k = 0; k < 4; k++) b[k] = old_w[8*k +: 8];
        if (o == 2'b00) begin
            b[off] = d[7:0];
        end else if (o == 2'b01) begin
            base = off[1] ? 2 : 0;
            b[base]     = d[7:0];
            b[base + 1] = d[15:8];
        end else if (o == 2'b10) begin
            for (int k = 0; k < 4; k++) b[k] = d[8*k +: 8];
        end
        return {b[3], b[2], b[1], b[0]};
    endfunction

    function automatic bit ref_reject(input logic [1:0] o, input logic [1:0] off);
`ifdef STORE_ALIGN_CHECK_EN
        return (o == 2'b01 && off[0]) || (o == 2'b10 && off != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Issues one request starting in the current cycle (cycle 0) and records what happens.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int poke_at, output obs_t r);
        int t0;
        int k;
        r = '{re_cyc: -1, we_cyc: -1, done_cyc: -1, n_re: 0, n_we: 0, we_data: 32'h0,
              we_addr: 32'h0, err: 1'b0, overlap: 1'b0, busy_bad: 1'b0, idle_after: 1'b0,
              hold_addr: 32'h0};
        t0 = cyc;
        if (o_busy !== 1'b0) r.busy_bad = 1'b1;
        op = o; addr = a; data = d; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            k = cyc - t0;
            start = 1'b0;
            if (k == poke_at) begin
                start = 1'b1; op = 2'b10; addr = 32'h0000_0F00; data = 32'h0BAD_0BAD;
            end
            if (o_re) begin r.n_re++; r.re_cyc = k; end
            if (o_we) begin r.n_we++; r.we_cyc = k; r.we_data = o_wdata; r.we_addr = o_addr; end
            if (o_re && o_we) r.overlap = 1'b1;
            if (o_busy !== 1'b1) r.busy_bad = 1'b1;
            if (o_done === 1'b1) begin r.done_cyc = k; r.err = o_err; break; end
        end
        @(negedge clk);
        start = 1'b0;
        r.idle_after = (o_busy === 1'b0) && (o_done === 1'b0) && (o_re === 1'b0) && (o_we === 1'b0);
        r.hold_addr  = o_addr;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus_a.busy, bus_a.done, bus_a.addr_err, bus_a.mem_re, bus_a.mem_we,
             bus_a.mem_addr, bus_a.mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_a: outputs not all zero (wdata=%h)", bus_a.mem_wdata);
        end
        checks++;
        if ({bus_b.busy, bus_b.done, bus_b.addr_err, bus_b.mem_re, bus_b.mem_we,
             bus_b.mem_addr, bus_b.mem_wdata} !== '0) begin
            errors++; $display("FAIL reset_b: outputs not all zero (wdata=%h)", bus_b.mem_wdata);
        end
    endtask

    task automatic test_sw();
        obs_t r;
        sel = 1'b0;
        run_op(2'b10, 32'h0000_0100, 32'hDEAD_BEEF, -1, r);
        checks++; if (r.we_cyc !== 1) begin errors++; $display("FAIL sw_we_cycle: got %0d want 1", r.we_cyc); end
        checks++; if (r.we_addr !== 32'h100) begin errors++; $display("FAIL sw_addr: got %h want 00000100", r.we_addr); end
        checks++; if (r.we_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_data: got %h want deadbeef", r.we_data); end
        checks++; if (r.n_re !== 0) begin errors++; $display("FAIL sw_no_read: got %0d reads want 0", r.n_re); end
        checks++; if (r.done_cyc !== 2) begin errors++; $display("FAIL sw_done_cycle: got %0d want 2", r.done_cyc); end
        checks++; if (r.busy_bad !== 1'b0 || r.idle_after !== 1'b1) begin
            errors++; $display("FAIL sw_busy: busy_bad=%b idle_after=%b want 0/1", r.busy_bad, r.idle_after);
        end
    endtask

    task automatic test_sb();
        obs_t r;
        sel = 1'b0;
        mem[32'h203 >> 2] = 32'h1122_3344;
        run_op(2'b00, 32'h0000_0203, 32'h0000_00AB, -1, r);
        checks++; if (r.re_cyc !== 1) begin errors++; $display("FAIL sb_re_cycle: got %0d want 1", r.re_cyc); end
        checks++; if (r.we_cyc !== 3) begin errors++; $display("FAIL sb_we_cycle: got %0d want 3", r.we_cyc); end
        checks++; if (r.we_data !== 32'hAB22_3344) begin errors++; $display("FAIL sb_data: got %h want ab223344", r.we_data); end
        checks++; if (r.we_addr !== 32'h200) begin errors++; $display("FAIL sb_addr: got %h want 00000200", r.we_addr); end
        checks++; if (r.done_cyc !== 4) begin errors++; $display("FAIL sb_done_cycle: got %0d want 4", r.done_cyc); end
    endtask

    task automatic test_sh();
        obs_t r;
        sel = 1'b0;
        mem[32'h302 >> 2] = 32'h5566_7788;
        run_op(2'b01, 32'h0000_0302, 32'h0000_CAFE, -1, r);
        checks++; if (r.we_data !== 32'hCAFE_7788) begin errors++; $display("FAIL sh_data: got %h want cafe7788", r.we_data); end
        checks++; if (r.done_cyc !== 4) begin errors++; $display("FAIL sh_done_cycle: got %0d want 4", r.done_cyc); end
    endtask

    task automatic test_lat3();
        obs_t r;
        sel = 1'b1;
        mem[32'h400 >> 2] = 32'h9988_7766;
        run_op(2'b00, 32'h0000_0400, 32'h0000_005A, 2, r);
        checks++; if (r.re_cyc !== 1) begin errors++; $display("FAIL lat3_re_cycle: got %0d want 1", r.re_cyc); end
        checks++; if (r.we_cyc !== 5) begin errors++; $display("FAIL lat3_we_cycle: got %0d want 5", r.we_cyc); end
        checks++; if (r.done_cyc !== 6) begin errors++; $display("FAIL lat3_done_cycle: got %0d want 6", r.done_cyc); end
        checks++; if (r.we_data !== 32'h9988_775A) begin errors++; $display("FAIL lat3_data: got %h want 9988775a", r.we_data); end
        checks++; if (r.n_we !== 1 || r.hold_addr !== 32'h400) begin
            errors++; $display("FAIL lat3_busy_start: writes=%0d addr=%h want 1/00000400", r.n_we, r.hold_addr);
        end
        sel = 1'b0;
    endtask

    task automatic test_align();
        obs_t r;
        sel = 1'b0;
        run_op(2'b10, 32'h0000_0102, 32'h7654_3210, -1, r);
`ifdef STORE_ALIGN_CHECK_EN
        checks++; if (r.done_cyc !== 1) begin errors++; $display("FAIL align_done_cycle: got %0d want 1", r.done_cyc); end
        checks++; if (r.err !== 1'b1) begin errors++; $display("FAIL align_err: got %b want 1", r.err); end
        checks++; if (r.n_re !== 0 || r.n_we !== 0) begin
            errors++; $display("FAIL align_no_access: reads=%0d writes=%0d want 0/0", r.n_re, r.n_we);
        end
`else
        checks++; if (r.we_cyc !== 1 || r.we_addr !== 32'h100) begin
            errors++; $display("FAIL align_off_write: cycle=%0d addr=%h want 1/00000100", r.we_cyc, r.we_addr);
        end
        checks++; if (r.err !== 1'b0) begin errors++; $display("FAIL align_off_err: got %b want 0", r.err); end
`endif
    endtask

    task automatic test_rsv();
        obs_t r;
        sel = 1'b0;
        run_op(2'b11, 32'h0123_4568, 32'hFFFF_FFFF, -1, r);
        checks++; if (r.done_cyc !== 1) begin errors++; $display("FAIL rsv_done_cycle: got %0d want 1", r.done_cyc); end
        checks++; if (r.n_re !== 0 || r.n_we !== 0 || r.err !== 1'b0) begin
            errors++; $display("FAIL rsv_noop: reads=%0d writes=%0d err=%b want 0/0/0", r.n_re, r.n_we, r.err);
        end
        checks++; if (r.hold_addr !== 32'h0123_4568) begin errors++; $display("FAIL rsv_addr: got %h want 01234568", r.hold_addr); end
    endtask

    task automatic test_back_to_back();
        obs_t r;
        sel = 1'b0;
        mem[32'h1C1 >> 2] = 32'hA1B2_C3D4;
        run_op(2'b10, 32'h0000_0180, 32'h0F0F_0F0F, 2, r);
        checks++; if (r.idle_after !== 1'b1 || r.hold_addr !== 32'h180) begin
            errors++; $display("FAIL b2b_done_start: idle_after=%b addr=%h want 1/00000180", r.idle_after, r.hold_addr);
        end
        run_op(2'b00, 32'h0000_01C1, 32'h0000_0077, -1, r);
        checks++; if (r.we_cyc !== 3 || r.we_data !== 32'hA1B2_77D4) begin
            errors++; $display("FAIL b2b_second: cycle=%0d data=%h want 3/a1b277d4", r.we_cyc, r.we_data);
        end
    endtask

    task automatic test_reset_mid();
        obs_t r;
        logic saw_we;
        logic bad_out;
        sel = 1'b0; saw_we = 1'b0; bad_out = 1'b0;
        op = 2'b00; addr = 32'h0000_0210; data = 32'h0000_0042; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_err, o_re, o_we, o_addr, o_wdata} !== '0) begin
            errors++; $display("FAIL midrst_outputs: busy=%b addr=%h want all zero", o_busy, o_addr);
        end
        repeat (3) begin
            @(negedge clk);
            if (o_we !== 1'b0) saw_we = 1'b1;
            if ({o_busy, o_done, o_re, o_addr, o_wdata} !== '0) bad_out = 1'b1;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_we !== 1'b0) saw_we = 1'b1;
        end
        checks++; if (saw_we !== 1'b0 || bad_out !== 1'b0) begin
            errors++; $display("FAIL midrst_no_write: saw_we=%b bad_out=%b want 0/0", saw_we, bad_out);
        end
        run_op(2'b10, 32'h0000_0120, 32'h1357_2468, -1, r);
        checks++; if (r.we_cyc !== 1 || r.we_data !== 32'h1357_2468 || r.done_cyc !== 2) begin
            errors++; $display("FAIL midrst_recover: we=%0d data=%h done=%0d want 1/13572468/2",
                               r.we_cyc, r.we_data, r.done_cyc);
        end
    endtask

    task automatic test_random();
        obs_t r;
        logic [1:0]  o;
        logic [31:0] a, d, old_w, exp_data;
        int lat, e_re, e_we, e_done;
        bit rej;
        for (int it = 0; it < 40; it++) begin
            sel = 1'($urandom_range(0, 1));
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            d = $urandom;
            old_w = $urandom;
            mem[a[11:2]] = old_w;
            lat = sel ? LAT_B : LAT_A;
            rej = ref_reject(o, a[1:0]);
            if (rej || o == 2'b11) begin e_re = -1; e_we = -1; e_done = 1; end
            else if (o == 2'b10)   begin e_re = -1; e_we = 1;  e_done = 2; end
            else                   begin e_re = 1;  e_we = 2 + lat; e_done = 3 + lat; end
            exp_data = ref_word(old_w, d, o, a[1:0]);
            run_op(o, a, d, -1, r);
            checks++; if (r.done_cyc !== e_done || r.re_cyc !== e_re || r.we_cyc !== e_we) begin
                errors++; $display("FAIL rand%0d_timing: re/we/done=%0d/%0d/%0d want %0d/%0d/%0d (op=%0d lat=%0d)",
                                   it, r.re_cyc, r.we_cyc, r.done_cyc, e_re, e_we, e_done, o, lat);
            end
            if (e_we > 0) begin
                checks++; if (r.we_data !== exp_data || r.we_addr !== {a[31:2], 2'b00}) begin
                    errors++; $display("FAIL rand%0d_write: data=%h addr=%h want %h/%h",
                                       it, r.we_data, r.we_addr, exp_data, {a[31:2], 2'b00});
                end
            end
            checks++; if (r.err !== rej || r.overlap !== 1'b0 || r.busy_bad !== 1'b0 || r.idle_after !== 1'b1) begin
                errors++; $display("FAIL rand%0d_flags: err=%b overlap=%b busy_bad=%b idle=%b want %b/0/0/1",
                                   it, r.err, r.overlap, r.busy_bad, r.idle_after, rej);
            end
            checks++; if (r.hold_addr !== {a[31:2], 2'b00}) begin
                errors++; $display("FAIL rand%0d_hold_addr: got %h want %h", it, r.hold_addr, {a[31:2], 2'b00});
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sel = 1'b0; op = 2'b00; addr = 32'h0; data = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_sw();
        test_sb();
        test_sh();
        test_lat3();
        test_align();
        test_rsv();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_rmw.md
# store_rmw

Store-path narrowing unit for the multicycle datapath, the write-side counterpart of the load/immediate extenders. It takes a 32-bit register value and a byte address from the control unit and executes SB/SH/SW against a word-wide data memory that has no byte enables. SB and SH use a read-modify-write sequence; SW writes directly. The unit sits between the control FSM and the data memory port and signals completion with a one-cycle done pulse.

## Interface
- ADDR_W, 32, byte address width.
- READ_LAT, 1, cycles from mem_re assertion until mem_rdata is valid; legal range 1..3.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 SB, 01 SH, 10 SW, 11 reserved (completes as no-op).
- addr  in  ADDR_W  byte address.
- data  in  32  store source (rt); SB uses [7:0], SH uses [15:0].
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- addr_err  out  1  misalignment flag, valid with done.
- mem_addr  out  ADDR_W  word address, with bits [1:0] always 0.
- mem_re  out  1  one-cycle read strobe.
- mem_we  out  1  one-cycle write strobe.
- mem_wdata  out  32  write data, valid while mem_we is high.
- mem_rdata  in  32  read data, valid READ_LAT cycles after mem_re.

## Operation
- FSM states: IDLE, RD, WAIT, WR, DONE.
- IDLE with start high: latch op, addr, data; set mem_addr = {addr[ADDR_W-1:2],2'b00}.
  - SW goes to WR.
  - SB and SH go to RD.
  - op 11 goes to DONE.
- RD: mem_re=1 for exactly one cycle, then go to WAIT.
- WAIT: a counter runs for READ_LAT cycles. In the last WAIT cycle, capture mem_rdata merged with the latched data into the write register, then go to WR.
- WR: mem_we=1 for one cycle, then go to DONE.
- DONE: done=1, then go to IDLE.
- Byte lanes are little-endian: lane k = bits [8k+7:8k].
  - SB replaces lane addr[1:0].
  - SH replaces lanes {addr[1],0} and {addr[1],1}.
  - SW replaces the whole word.
  - Unselected lanes keep their read value unchanged.
- Any start while busy is ignored; the latched operands do not change.
- Reset at any point: FSM goes to IDLE and all outputs return to 0. A write whose WR cycle has not yet been reached is never issued.
- Reset values: busy 0, done 0, addr_err 0, mem_re 0, mem_we 0, mem_addr 0, mem_wdata 0.

## Timing
- Cycle 0 is the cycle in which start is sampled.
- SW: mem_we in cycle 1, done in cycle 2.
- SB/SH: mem_re in cycle 1, WAIT in cycles 2..1+READ_LAT, mem_we in cycle 2+READ_LAT, done in cycle 3+READ_LAT. With READ_LAT=1: mem_we in cycle 3, done in cycle 4.
- mem_re and mem_we are never high in the same cycle.
- A start in the same cycle as done (which is still DONE, not IDLE) is ignored. The earliest back-to-back start is the cycle after done.
- mem_addr holds its value from cycle 1 until the next accepted start.

## Configuration
- STORE_ALIGN_CHECK_EN defined:
  - Misaligned means SH with addr[0]=1, or SW with addr[1:0]≠0.
  - A misaligned request goes IDLE→DONE with no mem_re and no mem_we.
  - addr_err=1 together with done.
- STORE_ALIGN_CHECK_EN undefined:
  - addr_err is tied to 0.
  - SH ignores addr[0]; SW ignores addr[1:0].
  - All requests execute normally.

## Structure
- Shared definitions file store_defs holds:
  - op encodings OP_SB, OP_SH, OP_SW, OP_RSV;
  - FSM state encodings;
  - the READ_LAT legal-range constants.
- Sub-module store_lane_merge (combinational):
  - inputs: old word, data, op, addr[1:0];
  - output: merged word.
  - It is instantiated once, on the WAIT capture path.

## Test plan
- SW: addr 0x100, data 0xDEADBEEF → mem_we in cycle 1 with mem_addr 0x100 and mem_wdata 0xDEADBEEF; no mem_re; done in cycle 2.
- SB: addr 0x203, data 0x000000AB, memory word 0x11223344 → mem_re in cycle 1, mem_wdata 0xAB223344 in cycle 3, done in cycle 4.
- SH: addr 0x302, data 0x0000CAFE, memory word 0x55667788 → mem_wdata 0xCAFE7788.
- READ_LAT=3 with SB at addr 0x400 → mem_we in cycle 5 and done in cycle 6; a start in cycle 2 is ignored.
- With STORE_ALIGN_CHECK_EN: SW at addr 0x102 → done with addr_err=1 in cycle 1; no mem_re and no mem_we. Without the macro, the same request writes to mem_addr 0x100.
- Reset asserted in cycle 2 of an SB → no mem_we ever appears, all outputs are 0, and a new SW is accepted normally after rst deasserts.
